// File: rtl/shift_add_multiplier_8_bit.sv
// shift_add_multiplier_8_bit: sequential unsigned 8x8 -> 16 shift-add multiplier around one full_adder_8_bit.
// Define MUL_ZERO_BYPASS_EN to skip the RUN phase when either operand is zero.
module full_adder_8_bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] s,
  output logic       c_out
);
  logic [8:0] c;
  assign c[0] = c_in;
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c_out = c[8];
endmodule

module shift_add_multiplier_8_bit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] p
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] m, acc, q, sum;
  logic [3:0] cnt;
  logic       c, zero;
  full_adder_8_bit u_add (
    .a(acc),
    .b(q[0] ? m : 8'h00),
    .c_in(1'b0),
    .s(sum),
    .c_out(c)
  );
`ifdef MUL_ZERO_BYPASS_EN
  assign zero = (a == 8'h00) || (b == 8'h00);
`else
  assign zero = 1'b0;
`endif
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? (zero ? DONE : RUN) : IDLE)
              : state == RUN  ? (cnt == 4'd7 ? DONE : RUN)
              : IDLE;
  // The adder carry becomes acc[7]; sum[0] drops into the top of q as the low product bits.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      m   <= 8'h00;
      acc <= 8'h00;
      q   <= 8'h00;
      cnt <= 4'd0;
      p   <= 16'h0000;
    end else if (state == IDLE && start) begin
      m   <= a;
      q   <= b;
      acc <= 8'h00;
      cnt <= 4'd0;
      if (zero) p <= 16'h0000;
    end else if (state == RUN) begin
      acc <= {c, sum[7:1]};
      q   <= {sum[0], q[7:1]};
      cnt <= cnt + 4'd1;
      if (cnt == 4'd7) p <= {c, sum[7:1], sum[0], q[7:1]};
    end
endmodule
